axil2apb_bridge: RTL and testbench
==================================

# axil2apb_bridge

AXI4-Lite responder that converts each single-beat AXI4-Lite read or write into one APB3 transfer on a single downstream APB target. It connects to the AXI4-Lite master port and gives the bus a path to slow or wait-stated peripheral registers. At most one transaction is in flight. Reads and writes are arbitrated fairly.

## Interface
- ADDR_W, 32, AXI/APB address width
- DATA_W, 32, AXI/APB data width
- TIMEOUT_CYCLES, 255, APB ACCESS-phase cycle limit; used only when the timeout feature is compiled in
- s_axi_aclk  in  1  clock; all logic on its rising edge
- s_axi_aresetn  in  1  reset, asynchronous, active-low
- s_axi_awvalid/awready  in/out  1  AW handshake; s_axi_awaddr  in  ADDR_W
- s_axi_wvalid/wready  in/out  1  W handshake; s_axi_wdata  in  DATA_W
- s_axi_bvalid/bready  out/in  1  B handshake; s_axi_bresp  out  2
- s_axi_arvalid/arready  in/out  1  AR handshake; s_axi_araddr  in  ADDR_W
- s_axi_rvalid/rready  out/in  1  R handshake; s_axi_rdata  out  DATA_W; s_axi_rresp  out  2
- paddr  out  ADDR_W  APB address
- psel, penable, pwrite  out  1  APB controls
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready, pslverr  in  1  APB completion and error

## Operation
- FSM states: IDLE, SETUP, ACCESS, WRESP, RRESP.
- IDLE behaviour:
  - A write is pending when awvalid and wvalid are both high. A read is pending when arvalid is high.
  - If only one kind is pending, it is granted.
  - If both are pending, the grant goes to the opposite of the last granted kind. last_grant resets to "read", so the first conflict grants the write.
- Granted write:
  - awready and wready are both high in the same cycle. They are combinational on state, valids and grant.
  - awaddr and wdata are latched. pwrite=1. Next state SETUP.
- Granted read:
  - arready is high. araddr is latched. pwrite=0. Next state SETUP.
- AW and W are never accepted separately. A lone awvalid or a lone wvalid waits.
- SETUP: psel=1, penable=0 for exactly one cycle, then ACCESS.
- ACCESS:
  - psel=1 and penable=1 until pready is sampled high.
  - On that edge, prdata and pslverr are captured, psel and penable drop, and the FSM moves to WRESP or RRESP.
- Response codes: bresp/rresp = 2'b10 (SLVERR) if pslverr was 1, else 2'b00. rdata = captured prdata.
- WRESP holds bvalid and RRESP holds rvalid, along with the data and resp, until the handshake. The FSM then returns to IDLE.
- paddr, pwdata and pwrite are stable from SETUP through the end of ACCESS. They hold their last values in other states.
- The address is passed through unmodified; there is no alignment check. DECERR is never generated.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, last_grant is read. Reset assertion takes effect immediately and asynchronously, including mid-ACCESS: psel drops without completing the transfer, and no response is issued.
- Write timeline, with the AW/W handshake at edge E0:
  - psel is high after E0.
  - penable is high after E1.
  - With pready=1 at E2, bvalid is high after E2.
  - Each wait-state cycle adds one cycle.
- Reads follow the same timeline with rvalid in place of bvalid.
- After the B/R handshake edge Eb, the FSM is in IDLE during the following cycle. The earliest next acceptance is the edge after Eb.
- No ready output is asserted outside IDLE. Backpressure on bready/rready stalls all new acceptance.

## Configuration
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering ACCESS and increments on each ACCESS cycle with pready=0.
  - If it reaches TIMEOUT_CYCLES, the transfer aborts: psel and penable drop and the response is SLVERR. For reads, rdata=0.
  - A late pready is ignored.
- Undefined: there is no counter, and ACCESS waits indefinitely for pready.

## Test plan
- Write addr 0x0, data 0x12345678, pready=1:
  - paddr=0x0, pwdata=0x12345678, pwrite=1.
  - bvalid rises 3 edges after the handshake, with bresp=00.
- Read addr 0x1, pready low for 3 ACCESS cycles, prdata=0xC0DE1234:
  - rvalid rises 6 edges after the AR handshake.
  - rdata=0xC0DE1234, rresp=00.
- Write with pslverr=1 on the completing cycle: bresp=10. The bridge then returns to IDLE and accepts the next read normally.
- Conflicts after reset:
  - awvalid, wvalid and arvalid all high in the same cycle: the write completes first, then the read.
  - A second simultaneous conflict grants the read first.
- bready held low 5 cycles with arvalid high: bvalid and bresp are stable, arready stays 0, and the read is accepted on the edge after the B handshake.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready stuck 0 on a read: psel drops after 16 ACCESS cycles, rresp=10, rdata=0.
- Separately, assert reset mid-ACCESS: all outputs are 0 immediately.

Source files
------------

// File: rtl/axil2apb_bridge.sv
`default_nettype none
// =====================================================================
// Module   : axil2apb_bridge
// Brief    : AXI4-Lite responder that turns each single-beat read or
//            write into one APB3 transfer. One transaction in flight,
//            fair (alternating) read/write arbitration on conflict.
// Options  : APB_TIMEOUT_EN - abort an ACCESS phase that waits
//            TIMEOUT_CYCLES cycles without pready (SLVERR response).
// Revision : 1.0 - initial release
// =====================================================================
module axil2apb_bridge #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              s_axi_aclk,
   input  logic              s_axi_aresetn,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   input  logic [DATA_W-1:0] s_axi_wdata,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   output logic [1:0]        s_axi_bresp,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   input  logic [ADDR_W-1:0] s_axi_araddr,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready,
   output logic [DATA_W-1:0] s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic [ADDR_W-1:0] paddr,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   localparam logic [1:0] c_RESP_OKAY   = 2'b00;
   localparam logic [1:0] c_RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_ACCESS = 3'd2,
      S_WRESP  = 3'd3,
      S_RRESP  = 3'd4
   } state_t;

   state_t              r_state;
   logic                r_last_wr;   // 1: last granted kind was a write
   logic [ADDR_W-1:0]   r_paddr;
   logic [DATA_W-1:0]   r_pwdata;
   logic                r_pwrite;
   logic                r_psel;
   logic                r_penable;
   logic                r_bvalid;
   logic [1:0]          r_bresp;
   logic                r_rvalid;
   logic [1:0]          r_rresp;
   logic [DATA_W-1:0]   r_rdata;

   logic                w_idle;
   logic                w_wr_pend;
   logic                w_rd_pend;
   logic                w_grant_wr;
   logic                w_grant_rd;

`ifdef APB_TIMEOUT_EN
   localparam int                 c_CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
   logic [c_CNT_W-1:0] r_to_cnt;
   logic               w_to_hit;
   // This wait-state cycle is the one that brings the count to the limit
   assign w_to_hit = (r_to_cnt == c_TO_LAST);
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

   // Readies are gated by reset so every output reads 0 while in reset
   assign w_idle     = (r_state == S_IDLE) && s_axi_aresetn;
   assign w_wr_pend  = s_axi_awvalid & s_axi_wvalid;
   assign w_rd_pend  = s_axi_arvalid;
   // On a conflict the kind that did not win last time is granted
   assign w_grant_wr = w_idle & w_wr_pend & (~w_rd_pend | ~r_last_wr);
   assign w_grant_rd = w_idle & w_rd_pend & (~w_wr_pend |  r_last_wr);

   assign s_axi_awready = w_grant_wr;
   assign s_axi_wready  = w_grant_wr;
   assign s_axi_arready = w_grant_rd;

   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bresp   = r_bresp;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rresp   = r_rresp;
   assign s_axi_rdata   = r_rdata;
   assign paddr         = r_paddr;
   assign psel          = r_psel;
   assign penable       = r_penable;
   assign pwrite        = r_pwrite;
   assign pwdata        = r_pwdata;

   // Transaction FSM: accept, run SETUP/ACCESS, hold the response
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_state   <= S_IDLE;
         r_last_wr <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
         r_pwrite  <= 1'b0;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= c_RESP_OKAY;
         r_rvalid  <= 1'b0;
         r_rresp   <= c_RESP_OKAY;
         r_rdata   <= '0;
`ifdef APB_TIMEOUT_EN
         r_to_cnt  <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_wr) begin
                  r_paddr   <= s_axi_awaddr;
                  r_pwdata  <= s_axi_wdata;
                  r_pwrite  <= 1'b1;
                  r_psel    <= 1'b1;
                  r_last_wr <= 1'b1;
                  r_state   <= S_SETUP;
               end else if (w_grant_rd) begin
                  r_paddr   <= s_axi_araddr;
                  r_pwrite  <= 1'b0;
                  r_psel    <= 1'b1;
                  r_last_wr <= 1'b0;
                  r_state   <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
               r_to_cnt  <= '0;
`endif
               r_state   <= S_ACCESS;
            end
            S_ACCESS: begin
               if (pready) begin
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  if (r_pwrite) begin
                     r_bvalid <= 1'b1;
                     r_bresp  <= pslverr ? c_RESP_SLVERR : c_RESP_OKAY;
                     r_state  <= S_WRESP;
                  end else begin
                     r_rvalid <= 1'b1;
                     r_rresp  <= pslverr ? c_RESP_SLVERR : c_RESP_OKAY;
                     r_rdata  <= prdata;
                     r_state  <= S_RRESP;
                  end
               end
`ifdef APB_TIMEOUT_EN
               else if (w_to_hit) begin
                  // Abandon the transfer; a pready arriving later is ignored
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  if (r_pwrite) begin
                     r_bvalid <= 1'b1;
                     r_bresp  <= c_RESP_SLVERR;
                     r_state  <= S_WRESP;
                  end else begin
                     r_rvalid <= 1'b1;
                     r_rresp  <= c_RESP_SLVERR;
                     r_rdata  <= '0;
                     r_state  <= S_RRESP;
                  end
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
`endif
            end
            S_WRESP: begin
               if (s_axi_bready) begin
                  r_bvalid <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            S_RRESP: begin
               if (s_axi_rready) begin
                  r_rvalid <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axil2apb_bridge.sv
`default_nettype none
// =====================================================================
// Module   : tb_axil2apb_bridge
// Brief    : Self-checking bench for axil2apb_bridge. A transaction-level
//            model predicts readies, APB phases and responses each cycle;
//            directed scenarios pin the model with literal values, then
//            randomized AXI/APB traffic runs against it.
// Options  : APB_TIMEOUT_EN - also exercises the ACCESS timeout (16).
// Revision : 1.0 - initial release
// =====================================================================
module tb_axil2apb_bridge;

`ifdef APB_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 255;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
   logic        bready = 1'b0, rready = 1'b0;
   logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
   logic        awready, wready, arready, bvalid, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata, paddr, pwdata;
   logic        psel, penable, pwrite;
   logic [31:0] prdata = '0;
   logic        pready = 1'b0, pslverr = 1'b0;

   always #5 clk = ~clk;

   axil2apb_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
      .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
      .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
      .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
      .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata),
      .s_axi_rresp(rresp),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
      .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   int n_cmp = 0;
   int n_err = 0;
   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic zero_chk(input string p);
      chk({p, "_awready"}, awready, 0); chk({p, "_wready"}, wready, 0);
      chk({p, "_arready"}, arready, 0); chk({p, "_bvalid"}, bvalid, 0);
      chk({p, "_bresp"}, bresp, 0);     chk({p, "_rvalid"}, rvalid, 0);
      chk({p, "_rresp"}, rresp, 0);     chk({p, "_rdata"}, rdata, 0);
      chk({p, "_paddr"}, paddr, 0);     chk({p, "_psel"}, psel, 0);
      chk({p, "_penable"}, penable, 0); chk({p, "_pwrite"}, pwrite, 0);
      chk({p, "_pwdata"}, pwdata, 0);
   endtask

   // ---------------- APB target: planned wait states and error ----------
   bit          dir_mode = 1'b1;
   int          dir_waits = 0;
   bit          dir_err = 1'b0;
   logic [31:0] dir_rdata = '0;
   int          acc_cyc = 0;
   int          cur_w = 0;
   bit          cur_e = 1'b0;
   logic [31:0] cur_d = '0;

   initial begin
      forever begin
         @(posedge clk); #1;
         if (psel && penable) begin
            if (acc_cyc == 0) begin
               cur_w = dir_mode ? dir_waits : int'($urandom_range(0, 3));
               cur_e = dir_mode ? dir_err : 1'($urandom_range(0, 1));
               cur_d = dir_mode ? dir_rdata : $urandom;
            end
            pready  = (acc_cyc == cur_w);
            pslverr = pready ? cur_e : 1'($urandom_range(0, 1));
            prdata  = pready ? cur_d : $urandom;
            acc_cyc++;
         end else begin
            acc_cyc = 0;
            pready  = 1'($urandom_range(0, 1));
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
         end
      end
   end

   // ---------------- transaction model + DUT-side log -------------------
   typedef struct {
      bit          wr;
      logic [31:0] pa;
      logic [31:0] data;
      logic [1:0]  resp;
      int          lat;      // edges from handshake edge to valid-rise edge, inclusive
      int          hs_edge;
   } rec_t;
   rec_t lg[$];

   bit          m_busy = 0, m_done = 0, m_wr = 0, m_last_wr = 0;
   int          m_cyc = 0, m_to = 0;
   logic [31:0] m_pa = '0, m_pwd = '0, m_rdata = '0;
   bit          m_pw = 0;
   logic [1:0]  m_resp = '0;
   int          c_hs = 0, last_b_hs_edge = 0;
   bit          prev_b = 0, prev_r = 0;

   initial begin
      bit   wp, rp, e_aw, e_ar, e_sel, e_en;
      rec_t rc;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            zero_chk("rst");
            m_busy = 0; m_done = 0; m_last_wr = 0; m_pa = '0; m_pwd = '0; m_pw = 0;
            prev_b = 0; prev_r = 0;
         end else begin
            wp    = awvalid && wvalid;
            rp    = arvalid;
            e_aw  = !m_busy && wp && (!rp || !m_last_wr);
            e_ar  = !m_busy && rp && (!wp || m_last_wr);
            e_sel = m_busy && !m_done;
            e_en  = e_sel && (m_cyc >= 2);
            chk("awready", awready, e_aw);
            chk("wready", wready, e_aw);
            chk("arready", arready, e_ar);
            chk("psel", psel, e_sel);
            chk("penable", penable, e_en);
            chk("paddr", paddr, m_pa);
            chk("pwdata", pwdata, m_pwd);
            chk("pwrite", pwrite, m_pw);
            chk("bvalid", bvalid, m_done && m_wr);
            chk("rvalid", rvalid, m_done && !m_wr);
            if (m_done && m_wr) chk("bresp", bresp, m_resp);
            if (m_done && !m_wr) begin
               chk("rresp", rresp, m_resp);
               chk("rdata", rdata, m_rdata);
            end

            // Record what the DUT did, for the literal pins
            if ((awvalid && awready && wvalid && wready) || (arvalid && arready))
               c_hs = edge_cnt + 1;
            if (bvalid && !prev_b) begin
               rc = '{wr: 1'b1, pa: paddr, data: pwdata, resp: bresp,
                      lat: edge_cnt - c_hs + 1, hs_edge: c_hs};
               lg.push_back(rc);
            end
            if (rvalid && !prev_r) begin
               rc = '{wr: 1'b0, pa: paddr, data: rdata, resp: rresp,
                      lat: edge_cnt - c_hs + 1, hs_edge: c_hs};
               lg.push_back(rc);
            end
            if (bvalid && bready) last_b_hs_edge = edge_cnt + 1;
            prev_b = bvalid;
            prev_r = rvalid;

            // Advance the model across the coming edge
            if (!m_busy) begin
               if (e_aw) begin
                  m_busy = 1; m_wr = 1; m_last_wr = 1; m_cyc = 1; m_to = 0;
                  m_pa = awaddr; m_pwd = wdata; m_pw = 1;
               end else if (e_ar) begin
                  m_busy = 1; m_wr = 0; m_last_wr = 0; m_cyc = 1; m_to = 0;
                  m_pa = araddr; m_pw = 0;
               end
            end else if (!m_done) begin
               if (m_cyc >= 2) begin
                  if (pready) begin
                     m_done  = 1;
                     m_resp  = pslverr ? 2'b10 : 2'b00;
                     m_rdata = prdata;
                  end else begin
`ifdef APB_TIMEOUT_EN
                     m_to++;
                     if (m_to == TO) begin
                        m_done = 1; m_resp = 2'b10; m_rdata = '0;
                     end
`endif
                  end
               end
               m_cyc++;
            end else if (m_wr ? bready : rready) begin
               m_busy = 0; m_done = 0;
            end
         end
      end
   end

   // ---------------- stimulus helpers -----------------------------------
   bit aw_hs = 0, ar_hs = 0;
   int nresp = 0;

   task automatic cycle();
      bit bh, rh;
      @(negedge clk);
      aw_hs = awvalid && awready && wvalid && wready;
      ar_hs = arvalid && arready;
      bh    = bvalid && bready;
      rh    = rvalid && rready;
      @(posedge clk); #1;
      if (aw_hs) begin awvalid = 0; wvalid = 0; end
      if (ar_hs) arvalid = 0;
      nresp += int'(bh) + int'(rh);
   endtask

   task automatic wait_resp(input int k, input string nm);
      int tgt;
      int i;
      tgt = nresp + k;
      for (i = 0; i < 200 && nresp < tgt; i++) cycle();
      chk({nm, "_responded"}, nresp >= tgt, 1);
   endtask

   task automatic pin(input string nm, input int idx, input bit wr, input logic [31:0] pa,
                      input logic [31:0] d, input logic [1:0] rs, input int lat);
      chk({nm, "_logged"}, lg.size() > idx, 1);
      if (lg.size() > idx) begin
         chk({nm, "_kind"}, lg[idx].wr, wr);
         chk({nm, "_paddr"}, lg[idx].pa, pa);
         chk({nm, "_data"}, lg[idx].data, d);
         chk({nm, "_resp"}, lg[idx].resp, rs);
         chk({nm, "_latency"}, lg[idx].lat, lat);
      end
   endtask

   // ---------------- main sequence --------------------------------------
   initial begin
      int  base;
      bit  reissued, seen;
      // Reset with requests already waiting: nothing may be accepted
      awvalid = 1; wvalid = 1; arvalid = 1; rst_n = 0;
      repeat (3) @(posedge clk);
      #1 awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
      @(negedge clk); #1 rst_n = 1;
      @(posedge clk); #1;

      // Plain write, no wait states
      dir_mode = 1; dir_waits = 0; dir_err = 0;
      awaddr = 32'h0; wdata = 32'h12345678; awvalid = 1; wvalid = 1;
      wait_resp(1, "wr_basic");
      pin("wr_basic", 0, 1, 32'h0, 32'h12345678, 2'b00, 3);

      // Read with three wait states
      dir_waits = 3; dir_rdata = 32'hC0DE1234;
      araddr = 32'h1; arvalid = 1;
      wait_resp(1, "rd_wait");
      pin("rd_wait", 1, 0, 32'h1, 32'hC0DE1234, 2'b00, 6);

      // Write answered with pslverr, then a normal read
      dir_waits = 1; dir_err = 1;
      awaddr = 32'h40; wdata = 32'hA5A5A5A5; awvalid = 1; wvalid = 1;
      wait_resp(1, "wr_err");
      pin("wr_err", 2, 1, 32'h40, 32'hA5A5A5A5, 2'b10, 4);
      dir_waits = 0; dir_err = 0; dir_rdata = 32'h600DF00D;
      araddr = 32'h44; arvalid = 1;
      wait_resp(1, "rd_after_err");
      pin("rd_after_err", 3, 0, 32'h44, 32'h600DF00D, 2'b00, 3);

      // Reset in the middle of ACCESS
      dir_waits = 10; araddr = 32'h80; arvalid = 1; seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cycle();
         seen = psel && penable;
      end
      chk("reach_access", seen, 1);
      #2 rst_n = 0;
      #1 zero_chk("async_rst");
      @(negedge clk); #1 rst_n = 1;
      @(posedge clk); #1;
      chk("no_resp_after_rst", lg.size(), 4);

      // Conflicts: write wins first, then read wins the re-presented conflict
      base = lg.size(); dir_waits = 0; dir_rdata = 32'h0BADCAFE;
      awaddr = 32'h100; wdata = 32'h11111111; araddr = 32'h200;
      awvalid = 1; wvalid = 1; arvalid = 1; reissued = 0;
      for (int i = 0; i < 60 && nresp < 0 + (nresp - 0) + 0 && 0; i++) cycle();
      begin
         int tgt;
         tgt = nresp + 3;
         for (int i = 0; i < 80 && nresp < tgt; i++) begin
            cycle();
            if (aw_hs && !reissued) begin
               awaddr = 32'h300; wdata = 32'h33333333; awvalid = 1; wvalid = 1;
               reissued = 1;
            end
         end
         chk("conflict_responded", nresp >= tgt, 1);
      end
      pin("cf_wr1", base, 1, 32'h100, 32'h11111111, 2'b00, 3);
      pin("cf_rd", base + 1, 0, 32'h200, 32'h0BADCAFE, 2'b00, 3);
      pin("cf_wr2", base + 2, 1, 32'h300, 32'h33333333, 2'b00, 3);

      // B backpressure with a read waiting
      base = lg.size(); bready = 0;
      awaddr = 32'h400; wdata = 32'h44444444; awvalid = 1; wvalid = 1;
      for (int i = 0; i < 20 && lg.size() <= base; i++) cycle();
      araddr = 32'h500; arvalid = 1;
      repeat (5) cycle();
      bready = 1;
      wait_resp(2, "bp");
      pin("bp_wr", base, 1, 32'h400, 32'h44444444, 2'b00, 3);
      pin("bp_rd", base + 1, 0, 32'h500, 32'h0BADCAFE, 2'b00, 3);
      if (lg.size() > base + 1) chk("bp_rd_accept_edge", lg[base + 1].hs_edge, last_b_hs_edge + 1);

      // Randomized traffic
      dir_mode = 0;
      for (int i = 0; i < 2500; i++) begin
         if (!awvalid && $urandom_range(0, 3) == 0) begin awvalid = 1; awaddr = $urandom; end
         if (!wvalid && $urandom_range(0, 3) == 0) begin wvalid = 1; wdata = $urandom; end
         if (!arvalid && $urandom_range(0, 3) == 0) begin arvalid = 1; araddr = $urandom; end
         bready = 1'($urandom_range(0, 1));
         rready = 1'($urandom_range(0, 1));
         cycle();
      end
      bready = 1; rready = 1;
      for (int i = 0; i < 300 && (awvalid || wvalid || arvalid || m_busy); i++) begin
         if (awvalid || wvalid) begin awvalid = 1; wvalid = 1; end
         cycle();
      end
      chk("drain_idle", awvalid || wvalid || arvalid || m_busy, 0);

`ifdef APB_TIMEOUT_EN
      // Target never answers: transfer is abandoned with SLVERR and rdata 0
      base = lg.size(); dir_mode = 1; dir_waits = 1000;
      araddr = 32'h600; arvalid = 1;
      wait_resp(1, "timeout_rd");
      pin("timeout_rd", base, 0, 32'h600, 32'h0, 2'b10, TO + 2);
      dir_waits = 0;
      repeat (3) cycle();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
